io_initiator: RTL
=================

// Module: io_initiator
// PURPOSE
//  Bus-master side of the 8-bit I/O space: turns a single-word request (read/write, address, data)
//  into a timed I/O bus cycle on addr / d7_d0 / ior_ / iow_ and returns read data with a done pulse.
//  Sits between the processor model and the I/O space decoder (keyboard RSR/RBR, display TSR/TBR).
//  One transfer at a time; no queueing.
// PARAMETERS
//  IO_SIZE        16  width of the I/O address bus
//  STROBE_CYCLES   2  clock cycles ior_/iow_ held low per transfer; legal range 1..15
// PORTS
//  clock     in     1        system clock; all state changes on rising edge
//  reset     in     1        asynchronous, active-high reset
//  req       in     1        transfer request; sampled only when busy=0
//  wr        in     1        1 = write, 0 = read; sampled with req
//  req_addr  in  IO_SIZE     target I/O address; sampled with req
//  wdata     in     8        write data; sampled with req
//  busy      out    1        1 from the cycle after acceptance through HOLD
//  done      out    1        one-cycle pulse: transfer complete, rdata valid (reads)
//  rdata     out    8        last read data; holds until the next read completes
//  addr      out  IO_SIZE    I/O address bus
//  d7_d0     inout  8        I/O data bus; driven only during write SETUP/STROBE/HOLD
//  ior_      out    1        read strobe, active low
//  iow_      out    1        write strobe, active low
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, addr=0, ior_=1, iow_=1, d7_d0=Z, busy=0, done=0, rdata=0.
//  All outputs registered; the d7_d0 enable is a registered flop.
//  FSM: IDLE -> SETUP -> STROBE (STROBE_CYCLES cycles) -> HOLD -> IDLE.
//   IDLE:   busy=0, strobes high, d7_d0=Z, addr holds last value. On edge with req=1: latch wr,
//           req_addr, wdata; go to SETUP.
//   SETUP:  busy=1, addr=latched address, strobes high; write: d7_d0 driven with wdata.
//   STROBE: write: iow_=0 and d7_d0 driven; read: ior_=0 and d7_d0=Z. A 4-bit down-counter is
//           loaded with STROBE_CYCLES-1 on entry; exit when the counter is 0.
//           Read: rdata captures d7_d0 on the edge that leaves STROBE.
//   HOLD:   strobes high; addr and (for writes) d7_d0 still driven, giving 1 cycle of hold time.
//   HOLD -> IDLE: done=1 for exactly that first IDLE cycle; busy=0 in the same cycle.
//  Timing: done is asserted STROBE_CYCLES+2 edges after the accepting edge. Default gives 4.
//  ior_ and iow_ are never low simultaneously. Address and data are stable for the full strobe
//  window plus one cycle on each side.
//  Boundary cases:
//   - req while busy=1: ignored, not queued; the request must be re-presented.
//   - req=1 in the done cycle: accepted; back-to-back transfers, SETUP follows immediately.
//   - req_addr/wdata/wr changing after acceptance: no effect on the transfer in progress.
//   - STROBE_CYCLES=1: STROBE lasts exactly one cycle; the counter is never decremented.
//   - reset mid-transfer: strobes deassert and d7_d0 is released asynchronously; no done pulse;
//     rdata returns to 0.
//  Data width: 8 bits only; no byte enables.
// TESTING
//  1 Read: req, wr=0, req_addr=16'h0001; bus model returns 8'h41 while ior_=0 ->
//    ior_ low 2 cycles; done 4 edges after acceptance; rdata=8'h41; d7_d0 never driven by DUT.
//  2 Write: req, wr=1, req_addr=16'h0003, wdata=8'h5A -> d7_d0=8'h5A for SETUP+STROBE+HOLD
//    (4 cycles); iow_ low 2 cycles; addr=16'h0003 throughout; ior_ stays 1.
//  3 Busy-drop: second req (addr 16'h0002) during STROBE -> ignored; exactly one bus cycle,
//    one done pulse.
//  4 Back-to-back: read 16'h0000 (device 8'h80), then req asserted in the done cycle for a read of
//    16'h0001 (8'h33) -> second SETUP starts the next cycle; rdata 8'h80 then 8'h33.
//  5 Reset mid-STROBE of a write -> iow_=1 and d7_d0=Z the same cycle; no done; busy=0.
//  6 STROBE_CYCLES=1 build: read 16'h0001 -> ior_ low 1 cycle; done 3 edges after acceptance.

Source files
------------

// File: rtl/io_initiator.sv
// io_initiator: bus-master for the 8-bit I/O space.
// This block turns a single-word request (read or write, address, data) into a timed
// I/O bus cycle on addr, d7_d0, ior_ and iow_. Read data comes back on rdata along
// with a one-cycle done pulse.
//
// Request handshake:
//   - req is sampled only on an edge where busy is 0 (this includes the done cycle).
//   - On that accepting edge, wr, req_addr and wdata are latched, and busy rises on
//     the next cycle.
//   - A req seen while busy is 1 is dropped rather than queued.
//   - done pulses for one cycle STROBE_CYCLES+2 edges after the accepting edge.
//
// All outputs come straight from flops, including the d7_d0 output enable, so that the
// strobes and the data bus never glitch.
module io_initiator #(
   parameter int IO_SIZE       = 16,
   parameter int STROBE_CYCLES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req,
   input  logic               wr,
   input  logic [IO_SIZE-1:0] req_addr,
   input  logic [7:0]         wdata,
   output logic               busy,
   output logic               done,
   output logic [7:0]         rdata,
   output logic [IO_SIZE-1:0] addr,
   inout  wire  [7:0]         d7_d0,
   output logic               ior_,
   output logic               iow_
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // The counter is loaded on entry to STROBE and counts down to zero,
   // so it gives STROBE_CYCLES cycles with the strobe low.
   localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [IO_SIZE-1:0] addr_q, addr_d;
   logic [7:0]         dout_q, dout_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ior_q, ior_d;
   logic               iow_q, iow_d;
   logic               oe_q, oe_d;

   // State register and registered outputs. Reset forces the strobes high and releases the bus immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ior_q   <= 1'b1;
         iow_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ior_q   <= ior_d;
         iow_q   <= iow_d;
         oe_q    <= oe_d;
      end
   end

   // Next-state logic, plus next values of the outputs decoded from the state being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               wr_d    = wr;
               addr_d  = req_addr;
               dout_d  = wdata;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               // Sample the bus on the edge that leaves STROBE. ior_ is still low at this edge.
               if (!wr_q) begin
                  rdata_d = d7_d0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Each output is decoded from the state being entered, so it changes on the same edge as the state.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_HOLD);
      ior_d  = !((state_d == ST_STROBE) && !wr_d);
      iow_d  = !((state_d == ST_STROBE) && wr_d);
      oe_d   = wr_d && (state_d != ST_IDLE);
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign addr  = addr_q;
   assign ior_  = ior_q;
   assign iow_  = iow_q;
   assign d7_d0 = oe_q ? dout_q : 8'hzz;

endmodule
